// File: rtl/gate_edge_counter_pkg.sv
// Shared types and default constants for the gate edge counter slice.
package gate_edge_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } filt_state_t;

  localparam int GE_SYNC_STAGES = 2;
  localparam int GE_FILT_LEN    = 3;
  localparam int GE_CNT_W       = 8;

endpackage

// File: rtl/gate_edge_counter_if.sv
// Snapshot handshake bundle: consumer (master) requests/accepts, counter (slave) supplies data.
interface gate_edge_counter_if #(
  parameter int CNT_W = gate_edge_pkg::GE_CNT_W
);
  logic             snap_req;
  logic             snap_valid;
  logic             snap_ready;
  logic [CNT_W-1:0] snap_rise;
  logic [CNT_W-1:0] snap_fall;

  modport master (
    output snap_req, snap_ready,
    input  snap_valid, snap_rise, snap_fall
  );

  modport slave (
    input  snap_req, snap_ready,
    output snap_valid, snap_rise, snap_fall
  );
endinterface

// File: rtl/gate_sync_filter.sv
// Synchronizes the asynchronous gate level and debounces it; emits the
// accepted level plus one-cycle pulses on accepted edges.
module gate_sync_filter
  import gate_edge_pkg::*;
#(
  parameter int SYNC_STAGES = GE_SYNC_STAGES,
  parameter int FILT_LEN    = GE_FILT_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inp,
  output logic filt,
  output logic rise_p,
  output logic fall_p
);
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;
  filt_state_t            state, state_d;
  logic [FW-1:0]          fcnt, fcnt_d;
  logic                   rise_q, rise_d, fall_q, fall_d;

  // Flop chain; only sync_ff[0] samples the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= '0;
    else        sync_ff <= {sync_ff[SYNC_STAGES-2:0], inp};
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

  // Filter state register; pulses are registered so they line up with filt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOW;
      fcnt   <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      state  <= state_d;
      fcnt   <= fcnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Next-state: a level is accepted after FILT_LEN consecutive samples.
  always_comb begin
    state_d = state;
    fcnt_d  = fcnt;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state)
      LOW: if (sync_q) begin
        if (FILT_LEN == 1) begin
          state_d = HIGH;
          rise_d  = 1'b1;
        end else begin
          state_d = RISE_WAIT;
          fcnt_d  = FW'(1);
        end
      end
      RISE_WAIT: begin
        if (!sync_q) begin
          state_d = LOW;
          fcnt_d  = '0;
        end else if (fcnt + FW'(1) == FW'(FILT_LEN)) begin
          state_d = HIGH;
          fcnt_d  = '0;
          rise_d  = 1'b1;
        end else begin
          fcnt_d  = fcnt + FW'(1);
        end
      end
      HIGH: if (!sync_q) begin
        if (FILT_LEN == 1) begin
          state_d = LOW;
          fall_d  = 1'b1;
        end else begin
          state_d = FALL_WAIT;
          fcnt_d  = FW'(1);
        end
      end
      FALL_WAIT: begin
        if (sync_q) begin
          state_d = HIGH;
          fcnt_d  = '0;
        end else if (fcnt + FW'(1) == FW'(FILT_LEN)) begin
          state_d = LOW;
          fcnt_d  = '0;
          fall_d  = 1'b1;
        end else begin
          fcnt_d  = fcnt + FW'(1);
        end
      end
      default: state_d = LOW;
    endcase
  end

  // Outputs: accepted level follows the state; pulses come from their flops.
  always_comb begin
    filt   = (state == HIGH) || (state == FALL_WAIT);
    rise_p = rise_q;
    fall_p = fall_q;
  end

endmodule

// File: rtl/gate_edge_counter.sv
// Counts debounced gate transitions in saturating counters and offers a
// snapshot of both counts over a valid/ready handshake.
module gate_edge_counter
  import gate_edge_pkg::*;
#(
  parameter int SYNC_STAGES = GE_SYNC_STAGES,
  parameter int FILT_LEN    = GE_FILT_LEN,
  parameter int CNT_W       = GE_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inp,
  input  logic                clr,
  output logic                filt,
  output logic                rise_p,
  output logic                fall_p,
  output logic                ovf,
  gate_edge_counter_if.slave  snap
);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] rise_cnt, fall_cnt;
  logic             accept;

  gate_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inp    (inp),
    .filt   (filt),
    .rise_p (rise_p),
    .fall_p (fall_p)
  );

  // Saturating counters; clr wins over a same-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
      ovf      <= 1'b0;
    end else if (clr) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (rise_p) begin
        if (rise_cnt == CMAX) ovf <= 1'b1;
        else                  rise_cnt <= rise_cnt + 1'b1;
      end
      if (fall_p) begin
        if (fall_cnt == CMAX) ovf <= 1'b1;
        else                  fall_cnt <= fall_cnt + 1'b1;
      end
    end
  end

  // A request is taken only when the output slot is free or being drained.
  assign accept = snap.snap_req && (!snap.snap_valid || snap.snap_ready);

  // Snapshot register: captures pre-increment counts; data holds after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap.snap_valid <= 1'b0;
      snap.snap_rise  <= '0;
      snap.snap_fall  <= '0;
    end else if (accept) begin
      snap.snap_valid <= 1'b1;
      snap.snap_rise  <= rise_cnt;
      snap.snap_fall  <= fall_cnt;
    end else if (snap.snap_valid && snap.snap_ready) begin
      snap.snap_valid <= 1'b0;
    end
  end

endmodule
